match_vector_player: RTL and testbench

Self-checking stimulus/response block for the 3-input `match4` combinational matcher. On a start pulse, it replays a fixed 8-step {A,B,C} vector sequence, holding each step for a programmed dwell. At the end of each dwell it samples the DUT's Y output and compares it with the expected value. It sits on the receiving end of the `match4` interface: it drives A/B/C and consumes Y, so the same check can run on the board and not only in simulation.

---
 rtl/match_pkg.sv | 34 +++
 rtl/dwell_timer.sv | 27 ++
 rtl/match_vector_player.sv | 149 ++++++++++++++
 tb/tb_match_vector_player.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared types and the fixed 8-step stimulus table for match_vector_player.
// Expected column is the 2-of-3 majority of {A,B,C}.
package match_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_STEPS = 8;
  // 15 dwell units x 255 ticks = 3825 cycles fits in 12 bits
  localparam int TIMER_W   = 12;

  localparam logic [2:0] STEP_VEC [NUM_STEPS] = '{
    3'b000, 3'b100, 3'b110, 3'b010, 3'b011, 3'b111, 3'b101, 3'b001
  };

  localparam logic [3:0] STEP_DWELL [NUM_STEPS] = '{
    4'd4, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd1, 4'd1
  };

  localparam logic STEP_EXP [NUM_STEPS] = '{
    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0
  };

  function automatic logic [TIMER_W-1:0] dwell_load(input logic [3:0] dwell,
                                                    input logic [7:0] tick_div);
    logic [TIMER_W-1:0] w_prod;
    w_prod = TIMER_W'(dwell) * TIMER_W'(tick_div);
    return w_prod - TIMER_W'(1);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; o_zero marks the last cycle of a dwell.
// Load takes priority over counting; the counter parks at zero.
module dwell_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/match_vector_player.sv
// Replays the 8-step {A,B,C} table into a match4 DUT and checks Y at the end of each dwell.
// Optional macro MATCH_FAIL_LOG_EN adds the fail_step port (first failing step index).
module match_vector_player
  import match_pkg::*;
#(
  parameter int unsigned TICK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_cnt
`ifdef MATCH_FAIL_LOG_EN
  ,
  output logic [2:0] fail_step
`endif
);

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_step, w_step_nxt, w_step_inc;
  logic [2:0]         r_vec, w_vec_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_pass, w_pass_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic               w_mis;
  logic               w_load;
  logic [TIMER_W-1:0] w_load_val;
  logic               w_zero;
`ifdef MATCH_FAIL_LOG_EN
  logic [2:0]         r_fail_step, w_fail_step_nxt;
`endif

  dwell_timer #(.W(TIMER_W)) u_dwell_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_vec       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_cnt       <= '0;
`ifdef MATCH_FAIL_LOG_EN
      r_fail_step <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_vec       <= w_vec_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_cnt       <= w_cnt_nxt;
`ifdef MATCH_FAIL_LOG_EN
      r_fail_step <= w_fail_step_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_vec_nxt   = r_vec;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_load_val  = dwell_load(STEP_DWELL[0], 8'(TICK_DIV));
    w_step_inc  = r_step + 3'd1;
    w_mis       = (y != STEP_EXP[r_step]);
    w_cnt_inc   = r_cnt + 4'(w_mis);
`ifdef MATCH_FAIL_LOG_EN
    w_fail_step_nxt = r_fail_step;
`endif

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = DRIVE;
          w_step_nxt  = 3'd0;
          w_vec_nxt   = STEP_VEC[0];
          w_busy_nxt  = 1'b1;
          w_pass_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
`ifdef MATCH_FAIL_LOG_EN
          w_fail_step_nxt = '0;
`endif
        end
      end
      DRIVE: begin
        // Timer at zero is the last cycle of the step: y has settled on this vector.
        if (w_zero) begin
          w_cnt_nxt = w_cnt_inc;
`ifdef MATCH_FAIL_LOG_EN
          if (w_mis && (r_cnt == '0)) begin
            w_fail_step_nxt = r_step;
          end
`endif
          if (r_step != 3'(NUM_STEPS - 1)) begin
            w_step_nxt = w_step_inc;
            w_vec_nxt  = STEP_VEC[w_step_inc];
            w_load     = 1'b1;
            w_load_val = dwell_load(STEP_DWELL[w_step_inc], 8'(TICK_DIV));
          end else begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_vec_nxt   = '0;
            w_pass_nxt  = (w_cnt_inc == '0);
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign a            = r_vec[2];
  assign b            = r_vec[1];
  assign c            = r_vec[0];
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign mismatch_cnt = r_cnt;
`ifdef MATCH_FAIL_LOG_EN
  assign fail_step    = r_fail_step;
`endif

endmodule

// File: tb/tb_match_vector_player.sv
// Bench for match_vector_player: emulated match4 (good and faulty) on y, timeline model per cycle.
// Optional macro MATCH_FAIL_LOG_EN enables fail_step checking.
module tb_match_vector_player;

  localparam int TICK = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       y;
  logic       a, b, c;
  logic       busy, done, pass;
  logic [3:0] mismatch_cnt;
`ifdef MATCH_FAIL_LOG_EN
  logic [2:0] fail_step;
`endif

  int mode = 0;  // 0: majority, 1: Y stuck at 0, 2: Y = A AND B
  int n_checks = 0;
  int n_fail = 0;

  int tb_vec [8]   = '{0, 4, 6, 2, 3, 7, 5, 1};
  int tb_dwell [8] = '{4, 1, 1, 1, 1, 2, 1, 1};
  int lit_cnt [3]  = '{0, 4, 2};
  int lit_fs [3]   = '{0, 2, 4};

  match_vector_player #(.TICK_DIV(TICK)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .y            (y),
    .a            (a),
    .b            (b),
    .c            (c),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .mismatch_cnt (mismatch_cnt)
`ifdef MATCH_FAIL_LOG_EN
    ,
    .fail_step    (fail_step)
`endif
  );

  always #5 clk = ~clk;

  function automatic int maj(input int v);
    return (((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1)) >= 2 ? 1 : 0;
  endfunction

  function automatic int y_of(input int md, input int v);
    if (md == 1) return 0;
    if (md == 2) return ((v >> 2) & 1) & ((v >> 1) & 1);
    return maj(v);
  endfunction

  assign y = (y_of(mode, int'({a, b, c})) != 0);

  function automatic int step_at(input int t);
    int acc = 0;
    for (int k = 0; k < 8; k++) begin
      acc += tb_dwell[k] * TICK;
      if (t < acc) return k;
    end
    return 7;
  endfunction

  // Mismatches among steps whose sample edge lies at or before offset t.
  function automatic int mis_upto(input int t, input int md);
    int acc = 0;
    int n = 0;
    for (int k = 0; k < 8; k++) begin
      acc += tb_dwell[k] * TICK;
      if (acc <= t && y_of(md, tb_vec[k]) != maj(tb_vec[k])) n++;
    end
    return n;
  endfunction

  function automatic int first_upto(input int t, input int md);
    int acc = 0;
    for (int k = 0; k < 8; k++) begin
      acc += tb_dwell[k] * TICK;
      if (acc <= t && y_of(md, tb_vec[k]) != maj(tb_vec[k])) return k;
    end
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t is the edge offset since the accepted start edge; run lasts offsets 0..60.
  bit m_active = 0;
  int m_t = 0;
  int m_mode = 0;
  int m_cnt = 0;
  int m_pass = 0;
  int m_fs = 0;
  int total_len = 0;

  always @(posedge clk) begin
    int e_abc, e_busy, e_done, e_cnt, e_pass, e_fs;
    if (rst) begin
      m_active = 0; m_t = 0; m_cnt = 0; m_pass = 0; m_fs = 0;
    end else if (m_active) begin
      if (m_t == total_len) begin
        m_active = 0;
        m_cnt  = mis_upto(total_len, m_mode);
        m_pass = (m_cnt == 0) ? 1 : 0;
        m_fs   = first_upto(total_len, m_mode);
      end else begin
        m_t++;
      end
    end else if (start) begin
      m_active = 1; m_t = 0; m_mode = mode;
    end
    #1;
    if (m_active && m_t < total_len) begin
      e_abc = tb_vec[step_at(m_t)]; e_busy = 1; e_done = 0; e_pass = 0;
      e_cnt = mis_upto(m_t, m_mode); e_fs = first_upto(m_t, m_mode);
    end else if (m_active) begin
      e_abc = 0; e_busy = 0; e_done = 1;
      e_cnt = mis_upto(total_len, m_mode);
      e_pass = (e_cnt == 0) ? 1 : 0;
      e_fs = first_upto(total_len, m_mode);
    end else begin
      e_abc = 0; e_busy = 0; e_done = 0; e_cnt = m_cnt; e_pass = m_pass; e_fs = m_fs;
    end
    check("abc", int'({a, b, c}), e_abc);
    check("busy", int'(busy), e_busy);
    check("done", int'(done), e_done);
    check("pass", int'(pass), e_pass);
    check("mismatch_cnt", int'(mismatch_cnt), e_cnt);
`ifdef MATCH_FAIL_LOG_EN
    check("fail_step", int'(fail_step), e_fs);
`else
    e_fs = e_fs;
`endif
  end

  task automatic run_once(input int md, input int repulse_at, input bit check_lens,
                          input bit start_in_done);
    int cyc = 0;
    int ndone = 0;
    int prev = -1;
    int cur = 0;
    int lens[$];
    int exp_lens [8] = '{20, 5, 5, 5, 5, 10, 5, 5};
    bit saw = 0;
    mode = md;
    @(negedge clk);
    start = 1'b1;
    while (cyc < 200 && !saw) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (repulse_at != 0) begin
        if (cyc == repulse_at) start = 1'b1;
        else if (cyc == repulse_at + 1) start = 1'b0;
      end
      if (busy) begin
        if (int'({a, b, c}) == prev && cur > 0) cur++;
        else begin
          if (cur > 0) lens.push_back(cur);
          prev = int'({a, b, c});
          cur = 1;
        end
      end
      if (done) begin
        saw = 1;
        ndone++;
      end
    end
    start = 1'b0;
    check("done_latency", saw ? cyc : -1, 61);
    if (cur > 0) lens.push_back(cur);
    if (check_lens) begin
      check("num_steps", lens.size(), 8);
      for (int k = 0; k < 8; k++)
        check("hold_len", (k < lens.size()) ? lens[k] : -1, exp_lens[k]);
    end
    if (start_in_done) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (done) ndone++;
    check("done_once", ndone, 1);
    check("idle_after_done", int'(busy), 0);
    check("lit_cnt", int'(mismatch_cnt), lit_cnt[md]);
    check("lit_pass", int'(pass), (lit_cnt[md] == 0) ? 1 : 0);
`ifdef MATCH_FAIL_LOG_EN
    check("lit_fail_step", int'(fail_step), lit_fs[md]);
`endif
  endtask

  initial begin
    int ndone;
    for (int k = 0; k < 8; k++) total_len += tb_dwell[k] * TICK;
    check("model_total_len", total_len, 60);
    check("model_stuck0_cnt", mis_upto(60, 1), 4);
    check("model_and_first", first_upto(60, 2), 4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    ndone = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("idle_done_count", ndone, 0);
    check("idle_abc", int'({a, b, c}), 0);
    check("idle_busy", int'(busy), 0);

    run_once(0, 0, 1, 1);
    run_once(1, 0, 0, 0);
    run_once(2, 0, 0, 0);
    run_once(1, 10, 0, 0);

    // Reset during step 3 of a stuck-at-0 run (one mismatch already counted).
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (31) @(posedge clk);
    @(negedge clk);
    check("pre_rst_cnt", int'(mismatch_cnt), 1);
    check("pre_rst_abc", int'({a, b, c}), 2);
    rst = 1'b1;
    #1;
    check("rst_abc", int'({a, b, c}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(mismatch_cnt), 0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("rst_no_done", ndone, 0);
    @(negedge clk);
    rst = 1'b0;
    run_once(0, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_once(int'($urandom_range(0, 2)), int'($urandom_range(2, 58)), 0,
               1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
